// File: rtl/sd_fifo_tx_burst_filler.sv
// sd_fifo_tx_burst_filler: read-only Wishbone burst master that keeps a
// first-word-fall-through FIFO topped up with data fetched from a linear
// address range. A burst is only launched once the FIFO has room for every
// beat of it, so the FIFO never sees a write while full.
module sd_fifo_tx_burst_filler #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 4,
    parameter int ADDR_INC  = DW / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [AW-1:0]            m_wb_adr_o,
    output logic                     m_wb_we_o,
    output logic [DW/8-1:0]          m_wb_sel_o,
    input  logic [DW-1:0]            m_wb_dat_i,
    output logic                     m_wb_cyc_o,
    output logic                     m_wb_stb_o,
    input  logic                     m_wb_ack_i,
    input  logic                     m_wb_err_i,
    output logic [2:0]               m_wb_cti_o,
    output logic [1:0]               m_wb_bte_o,
    input  logic                     en,
    input  logic [AW-1:0]            adr,
    input  logic [15:0]              blk_words,
    input  logic                     rd,
    output logic [DW-1:0]            dat_o,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     done,
    output logic                     err
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] DEPTH_PW  = PW'(DEPTH);
    localparam logic [15:0]   BL16      = 16'(BURST_LEN);
    localparam logic [15:0]   DEPTH16   = 16'(DEPTH);
    localparam logic [AW-1:0] INC_AW    = AW'(ADDR_INC);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_BURST = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   base_q;
    logic [AW-1:0]   offset_q;
    logic [15:0]     blk_q;
    logic [15:0]     cnt_q;
    logic [15:0]     beats_q;
    logic            cyc_q;
    logic [2:0]      cti_q;
    logic            done_q;
    logic            err_q;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic [PW-1:0]   level_s;
    logic            empty_s;
    logic [15:0]     rem_s;
    logic [15:0]     burst_n_s;
    logic [15:0]     free_s;
    logic            wr_en_s;
    logic            rd_en_s;
    logic            last_cnt_s;

    // Burst sizing, FIFO occupancy and push/pop strobes.
    always_comb begin
        level_s = wr_ptr_q - rd_ptr_q;
        empty_s = (level_s == {PW{1'b0}});
        free_s  = DEPTH16 - 16'(level_s);
        if (blk_q == 16'd0) begin
            rem_s = BL16;
        end else begin
            rem_s = blk_q - cnt_q;
        end
        if (rem_s < BL16) begin
            burst_n_s = rem_s;
        end else begin
            burst_n_s = BL16;
        end
        // Errored beats and beats racing an abort are never stored.
        wr_en_s    = en && cyc_q && (state_q == ST_BURST) && m_wb_ack_i && !m_wb_err_i;
        rd_en_s    = rd && !empty_s;
        last_cnt_s = (blk_q != 16'd0) && ((cnt_q + 16'd1) == blk_q);
    end

    // Next FIFO pointer values; wrap comes for free from the extra MSB.
    always_comb begin
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // FIFO pointers; a dropped enable flushes the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else if (!en) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[PW-2:0]] <= m_wb_dat_i;
        end
    end

    // Transfer FSM with registered bus controls and sticky status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            base_q   <= {AW{1'b0}};
            offset_q <= {AW{1'b0}};
            blk_q    <= 16'd0;
            cnt_q    <= 16'd0;
            beats_q  <= 16'd0;
            cyc_q    <= 1'b0;
            cti_q    <= CTI_CLASSIC;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (!en) begin
            state_q  <= ST_IDLE;
            offset_q <= {AW{1'b0}};
            cyc_q    <= 1'b0;
            cti_q    <= CTI_CLASSIC;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    base_q   <= adr;
                    blk_q    <= blk_words;
                    offset_q <= {AW{1'b0}};
                    cnt_q    <= 16'd0;
                    state_q  <= ST_ARM;
                end
                ST_ARM: begin
                    // Launch only when every beat of the burst fits.
                    if (free_s >= burst_n_s) begin
                        state_q <= ST_BURST;
                        cyc_q   <= 1'b1;
                        beats_q <= burst_n_s;
                        cti_q   <= (burst_n_s == 16'd1) ? CTI_CLASSIC : CTI_INCR;
                    end else begin
                        state_q <= ST_ARM;
                    end
                end
                ST_BURST: begin
                    if (m_wb_err_i) begin
                        cyc_q   <= 1'b0;
                        cti_q   <= CTI_CLASSIC;
                        err_q   <= 1'b1;
                        state_q <= ST_ERROR;
                    end else if (m_wb_ack_i) begin
                        offset_q <= offset_q + INC_AW;
                        cnt_q    <= cnt_q + 16'd1;
                        if (beats_q == 16'd1) begin
                            cyc_q <= 1'b0;
                            cti_q <= CTI_CLASSIC;
                            if (last_cnt_s) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_ARM;
                            end
                        end else begin
                            beats_q <= beats_q - 16'd1;
                            cti_q   <= (beats_q == 16'd2) ? CTI_END : CTI_INCR;
                        end
                    end else begin
                        state_q <= ST_BURST;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                ST_ERROR: begin
                    state_q <= ST_ERROR;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cyc_q   <= 1'b0;
                    cti_q   <= CTI_CLASSIC;
                end
            endcase
        end
    end

    assign m_wb_adr_o = base_q + offset_q;
    assign m_wb_we_o  = 1'b0;
    assign m_wb_sel_o = {(DW/8){1'b1}};
    assign m_wb_cyc_o = cyc_q;
    assign m_wb_stb_o = cyc_q;
    assign m_wb_cti_o = cti_q;
    assign m_wb_bte_o = 2'b00;
    assign dat_o      = mem_q[rd_ptr_q[PW-2:0]];
    assign empty      = empty_s;
    assign full       = (level_s == DEPTH_PW);
    assign level      = level_s;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sd_fifo_tx_burst_filler.sv
// Scoreboard bench for sd_fifo_tx_burst_filler: a zero-wait Wishbone slave
// returns address-derived data, a beat monitor checks address/cti against a
// burst model and queues the expected words, and pops compare dat_o.
module tb_sd_fifo_tx_burst_filler;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int BL = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] m_wb_adr_o;
    logic          m_wb_we_o;
    logic [3:0]    m_wb_sel_o;
    logic [DW-1:0] m_wb_dat_i;
    logic          m_wb_cyc_o, m_wb_stb_o;
    logic          m_wb_ack_i, m_wb_err_i;
    logic [2:0]    m_wb_cti_o;
    logic [1:0]    m_wb_bte_o;
    logic          en;
    logic [AW-1:0] adr;
    logic [15:0]   blk_words;
    logic          rd;
    logic [DW-1:0] dat_o;
    logic          empty, full;
    logic [4:0]    level;
    logic          done, err;

    logic          ack_en;
    logic [31:0]   err_addr;

    int            n_tests = 0;
    int            n_fail  = 0;

    logic [31:0]   m_base;
    logic [15:0]   m_blk;
    int            m_k;
    logic [31:0]   exp_q[$];

    sd_fifo_tx_burst_filler #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .BURST_LEN(BL), .ADDR_INC(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m_wb_adr_o(m_wb_adr_o), .m_wb_we_o(m_wb_we_o), .m_wb_sel_o(m_wb_sel_o),
        .m_wb_dat_i(m_wb_dat_i), .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
        .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i), .m_wb_cti_o(m_wb_cti_o),
        .m_wb_bte_o(m_wb_bte_o), .en(en), .adr(adr), .blk_words(blk_words),
        .rd(rd), .dat_o(dat_o), .empty(empty), .full(full), .level(level),
        .done(done), .err(err)
    );

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Expected cti of beat k: bursts start at multiples of BL.
    function automatic logic [2:0] exp_cti(input int k);
        int p, n, start;
        p = k % BL;
        start = k - p;
        if (m_blk == 16'd0) n = BL;
        else n = ((int'(m_blk) - start) < BL) ? (int'(m_blk) - start) : BL;
        if (n == 1) return 3'b000;
        return (p == n - 1) ? 3'b111 : 3'b010;
    endfunction

    // Zero-wait slave.
    assign m_wb_err_i = m_wb_cyc_o & m_wb_stb_o & (m_wb_adr_o == err_addr);
    assign m_wb_ack_i = m_wb_cyc_o & m_wb_stb_o & ack_en & ~m_wb_err_i;
    assign m_wb_dat_i = fdat(m_wb_adr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat monitor: a beat seen mid-cycle is accepted at the next edge.
    always @(negedge clk) begin
        if (rst && en && m_wb_cyc_o && m_wb_stb_o && m_wb_ack_i) begin
            check("beat_adr", m_wb_adr_o, m_base + 32'(4 * m_k));
            check("beat_cti", m_wb_cti_o, exp_cti(m_k));
            exp_q.push_back(fdat(m_base + 32'(4 * m_k)));
            m_k++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input logic [15:0] b);
        adr = a;
        blk_words = b;
        m_base = a;
        m_blk = b;
        m_k = 0;
        exp_q.delete();
        en = 1'b1;
    endtask

    task automatic stop_en();
        en = 1'b0;
        tick();
        exp_q.delete();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check(tag, done, 1);
    endtask

    task automatic wait_err(input string tag, input int budget);
        int n = 0;
        while (!err && n < budget) begin
            tick();
            n++;
        end
        check(tag, err, 1);
    endtask

    task automatic wait_level(input string tag, input int lvl, input int budget);
        int n = 0;
        while (int'(level) != lvl && n < budget) begin
            tick();
            n++;
        end
        check(tag, level, lvl);
    endtask

    task automatic pop(input string tag);
        logic [31:0] e;
        check({tag, "_sb"}, (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(tag, dat_o, e);
        end
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b0; rd = 1'b0; adr = '0; blk_words = 16'd0;
        ack_en = 1'b1; err_addr = 32'hFFFF_FFF0;
        m_base = '0; m_blk = 16'd0; m_k = 0;
        repeat (3) tick();
        check("rst_cyc", m_wb_cyc_o, 0);
        check("rst_stb", m_wb_stb_o, 0);
        check("rst_we", m_wb_we_o, 0);
        check("rst_cti", m_wb_cti_o, 0);
        check("rst_bte", m_wb_bte_o, 0);
        check("rst_sel", m_wb_sel_o, 4'hF);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        tick();

        // Two full bursts of a bounded block of 8.
        start(32'h1000, 16'd8);
        wait_done("b8_done", 100);
        check("b8_level", level, 8);
        check("b8_beats", m_k, 8);
        repeat (5) tick();
        check("b8_hold_done", done, 1);
        check("b8_hold_cyc", m_wb_cyc_o, 0);
        check("b8_hold_level", level, 8);
        for (int i = 0; i < 8; i++) pop("b8_dat");
        check("b8_empty", empty, 1);
        stop_en();
        check("b8_clr_done", done, 0);

        // 6 words: 4-beat burst then 2-beat burst.
        start(32'h2000, 16'd6);
        wait_done("b6_done", 100);
        check("b6_level", level, 6);
        check("b6_beats", m_k, 6);
        for (int i = 0; i < 6; i++) pop("b6_dat");
        stop_en();

        // Unbounded: stops at full, refills after 4 pops, wraps pointers.
        start(32'h3000, 16'd0);
        wait_level("ub_full_lvl", 16, 200);
        check("ub_full", full, 1);
        repeat (20) tick();
        check("ub_stall_lvl", level, 16);
        check("ub_stall_cyc", m_wb_cyc_o, 0);
        check("ub_stall_beats", m_k, 16);
        for (int i = 0; i < 4; i++) pop("ub_dat_a");
        wait_level("ub_refill", 16, 50);
        check("ub_refill_beats", m_k, 20);
        repeat (10) tick();
        check("ub_refill_cyc", m_wb_cyc_o, 0);
        check("ub_refill_lvl", level, 16);
        ack_en = 1'b0;
        for (int i = 0; i < 16; i++) pop("ub_dat_wrap");
        check("ub_drain_empty", empty, 1);
        check("ub_drain_beats", m_k, 20);
        stop_en();
        ack_en = 1'b1;

        // Bus error on the second beat.
        err_addr = 32'h4004;
        start(32'h4000, 16'd8);
        wait_err("er_flag", 50);
        check("er_cyc", m_wb_cyc_o, 0);
        check("er_level", level, 1);
        repeat (10) tick();
        check("er_hold_err", err, 1);
        check("er_hold_cyc", m_wb_cyc_o, 0);
        check("er_hold_level", level, 1);
        check("er_beats", m_k, 1);
        pop("er_dat");
        stop_en();
        check("er_clr", err, 0);
        err_addr = 32'hFFFF_FFF0;

        // Abort mid-burst at level 5, then restart from offset 0.
        start(32'h5000, 16'd0);
        wait_level("ab_lvl5", 5, 50);
        check("ab_cyc_before", m_wb_cyc_o, 1);
        en = 1'b0;
        tick();
        exp_q.delete();
        check("ab_cyc", m_wb_cyc_o, 0);
        check("ab_level", level, 0);
        check("ab_empty", empty, 1);
        check("ab_done", done, 0);
        start(32'h5000, 16'd4);
        wait_done("ab_re_done", 50);
        check("ab_re_level", level, 4);
        for (int i = 0; i < 4; i++) pop("ab_re_dat");
        stop_en();

        // Simultaneous pop and ack at level 3.
        start(32'h6000, 16'd8);
        wait_level("ra_lvl3", 3, 50);
        check("ra_cyc", m_wb_cyc_o, 1);
        pop("ra_dat0");
        check("ra_level", level, 3);
        wait_done("ra_done", 50);
        check("ra_level_end", level, 7);
        for (int i = 0; i < 7; i++) pop("ra_dat");
        stop_en();

        // Reset mid-burst acts immediately.
        start(32'h7000, 16'd0);
        wait_level("rs_lvl2", 2, 50);
        rst = 1'b0;
        #1;
        check("rs_cyc", m_wb_cyc_o, 0);
        check("rs_level", level, 0);
        check("rs_empty", empty, 1);
        check("rs_cti", m_wb_cti_o, 0);
        tick();
        check("rs_level_hold", level, 0);
        en = 1'b0;
        rst = 1'b1;
        tick();
        exp_q.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
